adc_scan_sequencer: RTL and testbench

- Controller for the MAX10 built-in ADC command/response interface.
- Round-robins conversions over up to NUM_SLOTS software-configured channel slots and issues one command at a time.
- Checks each returned response against the outstanding channel, then deposits the sample into that slot's output register with a one-cycle strobe.
- Sits between the ADC IP and the transceiver/capture datapath in the ADC clock domain; replaces a hard-wired command_valid=1.

---
 rtl/adc_scan_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// Round-robin command/response sequencer for the MAX10 ADC IP.
// Define ADC_SCAN_AVERAGE_EN to report the mean of every 4 samples per slot.
module adc_scan_sequencer #(
  parameter int NUM_SLOTS = 4,
  parameter int CHANNEL_W = 5,
  parameter int DATA_W    = 12,
  parameter int TIMEOUT   = 1023
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SLOTS*CHANNEL_W-1:0] slot_channel_in,
  input  logic [NUM_SLOTS-1:0]           slot_enable_in,
  output logic                           command_valid_out,
  output logic [CHANNEL_W-1:0]           command_channel_out,
  output logic                           command_startofpacket_out,
  output logic                           command_endofpacket_out,
  input  logic                           command_ready_in,
  input  logic                           response_valid_in,
  input  logic [CHANNEL_W-1:0]           response_channel_in,
  input  logic [DATA_W-1:0]              response_data_in,
  output logic [NUM_SLOTS*DATA_W-1:0]    sample_data_out,
  output logic [NUM_SLOTS-1:0]           sample_stb_out,
  output logic                           busy_out,
  output logic                           error_out,
  input  logic                           error_clear_in
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        last_q, last_d;
  logic [SW-1:0]        sel_q, sel_d;
  logic [CHANNEL_W-1:0] chan_q, chan_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;
  logic                 valid_q, valid_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    data_q [NUM_SLOTS];
  logic [DATA_W-1:0]    data_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] stb_q, stb_d;

  logic          any_en;
  logic          nxt_found;
  logic [SW-1:0] nxt_idx, lo_idx, hi_idx;
  logic          wr_en, err_set;

  // Next slot is searched strictly after last_q, ending on last_q itself.
  always_comb begin
    any_en    = |slot_enable_in;
    nxt_found = 1'b0;
    nxt_idx   = '0;
    lo_idx    = '0;
    hi_idx    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_enable_in[i]) lo_idx = SW'(i);
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_enable_in[i]) hi_idx = SW'(i);
    end
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      if (!nxt_found &&
          slot_enable_in[(int'(last_q) + i) % NUM_SLOTS]) begin
        nxt_found = 1'b1;
        nxt_idx   = SW'((int'(last_q) + i) % NUM_SLOTS);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    chan_d  = chan_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    valid_d = valid_q;
    tmo_d   = tmo_q;
    wr_en   = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        err_set = response_valid_in;
        if (any_en) begin
          sel_d   = nxt_idx;
          chan_d  = slot_channel_in[int'(nxt_idx)*CHANNEL_W +: CHANNEL_W];
          sop_d   = (nxt_idx == lo_idx);
          eop_d   = (nxt_idx == hi_idx);
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        err_set = response_valid_in;
        if (command_ready_in) begin
          valid_d = 1'b0;
          last_d  = sel_q;
          tmo_d   = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // A response arriving with the timeout still counts.
        if (response_valid_in) begin
          state_d = IDLE;
          if (response_channel_in == chan_q) wr_en = 1'b1;
          else err_set = 1'b1;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_d = err_set | (err_q & ~error_clear_in);

`ifdef ADC_SCAN_AVERAGE_EN
  logic [1:0]        cnt_q [NUM_SLOTS];
  logic [1:0]        cnt_d [NUM_SLOTS];
  logic [DATA_W+1:0] acc_q [NUM_SLOTS];
  logic [DATA_W+1:0] acc_d [NUM_SLOTS];
  logic [DATA_W+1:0] sum;

  always_comb begin
    stb_d  = '0;
    data_d = data_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    sum    = acc_q[sel_q] + (DATA_W+2)'(response_data_in);
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (!slot_enable_in[k]) begin
        cnt_d[k] = '0;
        acc_d[k] = '0;
      end
    end
    if (wr_en) begin
      if (cnt_q[sel_q] == 2'd3) begin
        data_d[sel_q] = DATA_W'(sum >> 2);
        stb_d[sel_q]  = 1'b1;
        acc_d[sel_q]  = '0;
        cnt_d[sel_q]  = '0;
      end else begin
        acc_d[sel_q] = sum;
        cnt_d[sel_q] = cnt_q[sel_q] + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        cnt_q[k] <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end
`else
  always_comb begin
    stb_d  = '0;
    data_d = data_q;
    if (wr_en) begin
      data_d[sel_q] = response_data_in;
      stb_d[sel_q]  = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SW'(NUM_SLOTS - 1);
      sel_q   <= '0;
      chan_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      valid_q <= 1'b0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      stb_q   <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) data_q[k] <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      chan_q  <= chan_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_pack
    assign sample_data_out[k*DATA_W +: DATA_W] = data_q[k];
  end

  assign command_valid_out         = valid_q;
  assign command_channel_out       = chan_q;
  assign command_startofpacket_out = sop_q;
  assign command_endofpacket_out   = eop_q;
  assign sample_stb_out            = stb_q;
  assign busy_out                  = (state_q != IDLE);
  assign error_out                 = err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: vector table, scoreboard of slot writes,
// and directed sequences for back-pressure, errors, timeout and reset.
module tb_adc_scan_sequencer;

  localparam int NS = 4;
  localparam int CW = 5;
  localparam int DW = 12;
  localparam int TMO = 15;
  localparam logic [NS*CW-1:0] CH_DEF = {5'd3, 5'd7, 5'd1, 5'd2};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NS*CW-1:0] slot_channel_in = CH_DEF;
  logic [NS-1:0]    slot_enable_in = '0;
  logic             command_valid_out;
  logic [CW-1:0]    command_channel_out;
  logic             command_startofpacket_out;
  logic             command_endofpacket_out;
  logic             command_ready_in = 1'b0;
  logic             response_valid_in = 1'b0;
  logic [CW-1:0]    response_channel_in = '0;
  logic [DW-1:0]    response_data_in = '0;
  logic [NS*DW-1:0] sample_data_out;
  logic [NS-1:0]    sample_stb_out;
  logic             busy_out;
  logic             error_out;
  logic             error_clear_in = 1'b0;

  adc_scan_sequencer #(
    .NUM_SLOTS(NS), .CHANNEL_W(CW), .DATA_W(DW), .TIMEOUT(TMO)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .slot_channel_in          (slot_channel_in),
    .slot_enable_in           (slot_enable_in),
    .command_valid_out        (command_valid_out),
    .command_channel_out      (command_channel_out),
    .command_startofpacket_out(command_startofpacket_out),
    .command_endofpacket_out  (command_endofpacket_out),
    .command_ready_in         (command_ready_in),
    .response_valid_in        (response_valid_in),
    .response_channel_in      (response_channel_in),
    .response_data_in         (response_data_in),
    .sample_data_out          (sample_data_out),
    .sample_stb_out           (sample_stb_out),
    .busy_out                 (busy_out),
    .error_out                (error_out),
    .error_clear_in           (error_clear_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0] en;
    logic [CW-1:0] rch;
    logic [DW-1:0] data;
    logic [CW-1:0] exp_ch;
    logic          exp_sop;
    logic          exp_eop;
    int            exp_slot;
  } vec_t;

  typedef struct {
    int            slot;
    logic [DW-1:0] data;
  } sb_t;

  int   n_checks = 0;
  int   n_fail = 0;
  sb_t  sb[$];
  sb_t  mon_e;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every strobe must match the oldest expected slot write.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NS; k++) begin
        if (sample_stb_out[k]) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: slot %0d data %0h, none expected",
                     k, sample_data_out[k*DW +: DW]);
          end else begin
            mon_e = sb.pop_front();
            check("stb_slot", 64'(k), 64'(mon_e.slot));
            check("stb_data", 64'(sample_data_out[k*DW +: DW]),
                  64'(mon_e.data));
          end
        end
      end
    end
  end

  // Serve one command: wait for valid (ready must already be high),
  // respond lat cycles after acceptance, return one cycle after response.
  task automatic run_conv(input int lat, input logic [CW-1:0] rch,
                          input logic [DW-1:0] d, input bit wr,
                          input int slot, input bit clr,
                          output logic [CW-1:0] cch,
                          output logic csop, output logic ceop);
    int n;
    n = 0;
    cch = '0;
    csop = 1'b0;
    ceop = 1'b0;
    while (!command_valid_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!command_valid_out) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_wait: valid=0 after %0d cycles, required 1", n);
      return;
    end
    cch  = command_channel_out;
    csop = command_startofpacket_out;
    ceop = command_endofpacket_out;
    @(negedge clk);
    repeat (lat - 1) @(negedge clk);
    response_valid_in   = 1'b1;
    response_channel_in = rch;
    response_data_in    = d;
    error_clear_in      = clr;
    if (wr) sb.push_back('{slot, d});
    @(negedge clk);
    response_valid_in = 1'b0;
    error_clear_in    = 1'b0;
  endtask

  task automatic clear_err();
    error_clear_in = 1'b1;
    @(negedge clk);
    error_clear_in = 1'b0;
    check("err_clear", 64'(error_out), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] cch;
    logic          csop, ceop;
    logic          bad;

    vecs[0] = '{4'b0101, 5'd2, 12'h123, 5'd2, 1'b1, 1'b0, 0};
    vecs[1] = '{4'b0101, 5'd7, 12'h456, 5'd7, 1'b0, 1'b1, 2};
    vecs[2] = '{4'b0101, 5'd2, 12'h0AA, 5'd2, 1'b1, 1'b0, 0};
    vecs[3] = '{4'b0101, 5'd7, 12'h0BB, 5'd7, 1'b0, 1'b1, 2};
    vecs[4] = '{4'b1111, 5'd3, 12'hFFF, 5'd3, 1'b0, 1'b1, 3};
    vecs[5] = '{4'b1111, 5'd2, 12'h001, 5'd2, 1'b1, 1'b0, 0};
    vecs[6] = '{4'b0010, 5'd1, 12'h800, 5'd1, 1'b1, 1'b1, 1};
    vecs[7] = '{4'b0010, 5'd1, 12'h7FF, 5'd1, 1'b1, 1'b1, 1};

    repeat (2) @(negedge clk);
    check("rst_outputs",
          {command_valid_out, command_channel_out,
           command_startofpacket_out, command_endofpacket_out,
           sample_stb_out, busy_out, error_out}, 64'd0);
    check("rst_samples", 64'(sample_data_out), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_enable", {busy_out, command_valid_out}, 64'd0);
    command_ready_in = 1'b1;

`ifdef ADC_SCAN_AVERAGE_EN
    slot_enable_in = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] smp;
      smp = (i == 3) ? 12'd104 : 12'(100 + i);
      run_conv(2, 5'd2, smp, 1'b0, 0, 1'b0, cch, csop, ceop);
      if (i == 3) sb.push_back('{0, 12'd101});
      @(negedge clk);
      check("avg_cmd_ch", 64'(cch), 64'd2);
    end
    slot_enable_in = '0;
    repeat (4) @(negedge clk);
    check("avg_value", 64'(sample_data_out[DW-1:0]), 64'd101);
    check("avg_err", 64'(error_out), 64'd0);
`else
    for (int i = 0; i < 8; i++) begin
      slot_enable_in = vecs[i].en;
      run_conv(2, vecs[i].rch, vecs[i].data, 1'b1, vecs[i].exp_slot,
               1'b0, cch, csop, ceop);
      check("vec_ch", 64'(cch), 64'(vecs[i].exp_ch));
      check("vec_sop_eop", {csop, ceop},
            {vecs[i].exp_sop, vecs[i].exp_eop});
      check("vec_stb", 64'(sample_stb_out), 64'(1 << vecs[i].exp_slot));
      check("vec_err", 64'(error_out), 64'd0);
    end
    slot_enable_in = '0;
    check("table_samples", 64'(sample_data_out),
          64'({12'hFFF, 12'h0BB, 12'h7FF, 12'h001}));

    // Back-pressure: command frozen while ready is low.
    command_ready_in = 1'b0;
    slot_enable_in   = 4'b0001;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_cmd",
            {command_valid_out, command_channel_out,
             command_startofpacket_out, command_endofpacket_out},
            {1'b1, 5'd2, 1'b1, 1'b1});
      slot_channel_in = 20'($urandom);
      slot_enable_in  = 4'($urandom_range(1, 15));
    end
    slot_channel_in  = CH_DEF;
    slot_enable_in   = 4'b0001;
    command_ready_in = 1'b1;
    run_conv(2, 5'd2, 12'h321, 1'b1, 0, 1'b0, cch, csop, ceop);
    slot_enable_in = '0;
    check("hold_release_ch", 64'(cch), 64'd2);

    // Channel mismatch, clear, clear racing a new mismatch.
    slot_enable_in = 4'b0001;
    run_conv(2, 5'd9, 12'hABC, 1'b0, 0, 1'b0, cch, csop, ceop);
    slot_enable_in = '0;
    check("mis_err", 64'(error_out), 64'd1);
    check("mis_slot0", 64'(sample_data_out[DW-1:0]), 64'h321);
    check("mis_stb", 64'(sample_stb_out), 64'd0);
    clear_err();
    slot_enable_in = 4'b0001;
    run_conv(2, 5'd9, 12'hABC, 1'b0, 0, 1'b1, cch, csop, ceop);
    slot_enable_in = '0;
    check("clr_vs_err", 64'(error_out), 64'd1);
    clear_err();

    // Timeout, then the next slot is issued.
    slot_enable_in = 4'b0101;
    bad = 1'b0;
    for (int c = 0; c < 50 && !command_valid_out; c++) @(negedge clk);
    check("tmo_cmd_ch", {command_valid_out, command_channel_out},
          {1'b1, 5'd7});
    @(negedge clk);
    for (int c = 0; c < TMO; c++) begin
      if (error_out) bad = 1'b1;
      @(negedge clk);
    end
    check("tmo_early", 64'(bad), 64'd0);
    check("tmo_err", 64'(error_out), 64'd1);
    @(negedge clk);
    check("tmo_next_cmd",
          {command_valid_out, command_channel_out,
           command_startofpacket_out},
          {1'b1, 5'd2, 1'b1});
    run_conv(2, 5'd2, 12'h5A5, 1'b1, 0, 1'b0, cch, csop, ceop);
    slot_enable_in = '0;
    clear_err();

    // Reset while waiting for a response; late response after release.
    slot_enable_in = 4'b0001;
    for (int c = 0; c < 50 && !command_valid_out; c++) @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 64'(busy_out), 64'd1);
    rst_n = 1'b0;
    slot_enable_in = 4'b0101;
    #1;
    check("mid_rst_outputs",
          {command_valid_out, command_channel_out,
           command_startofpacket_out, command_endofpacket_out,
           sample_stb_out, busy_out, error_out}, 64'd0);
    check("mid_rst_samples", 64'(sample_data_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    response_valid_in   = 1'b1;
    response_channel_in = 5'd2;
    response_data_in    = 12'hEEE;
    @(negedge clk);
    response_valid_in = 1'b0;
    check("late_resp_err", 64'(error_out), 64'd1);
    check("restart_slot0",
          {command_valid_out, command_channel_out,
           command_startofpacket_out, command_endofpacket_out},
          {1'b1, 5'd2, 1'b1, 1'b0});
    run_conv(2, 5'd2, 12'h777, 1'b1, 0, 1'b0, cch, csop, ceop);
    slot_enable_in = '0;
    check("post_rst_samples", 64'(sample_data_out),
          64'({12'h000, 12'h000, 12'h000, 12'h777}));
    clear_err();
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
